// File: rtl/contador_cascata_pkg.sv
// Shared definitions for the cascaded modulo-MOD counter: default geometry
// plus the helpers for load clamping and per-direction terminal values.
package contador_cascata_pkg;

  localparam int unsigned DEF_MOD   = 10;
  localparam int unsigned DEF_WIDTH = 4;

  // A loaded slice can never exceed the top legal digit value.
  function automatic int unsigned clamp_slice(input int unsigned value,
                                              input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

  // Down-counting ends at 0, up-counting ends at MOD-1.
  function automatic int unsigned terminal_value(input logic up,
                                                 input int unsigned modulus);
    return up ? modulus - 1 : 0;
  endfunction

endpackage

// File: rtl/contador_cascata_digito.sv
// One modulo-MOD digit: clear > load > step > hold, with an at-terminal flag
// that tells the next digit in the chain when it may step.
module contador_digito
  import contador_cascata_pkg::*;
#(
  parameter int unsigned MOD   = DEF_MOD,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             up,
  output logic [WIDTH-1:0] value,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= WIDTH'(clamp_slice(int'(load_val), MOD));
    end else if (step) begin
      if (up) value <= (value == MAX_V) ? '0 : value + 1'b1;
      else    value <= (value == '0) ? MAX_V : value - 1'b1;
    end
  end

  assign at_term = (value == WIDTH'(terminal_value(up, MOD)));

endmodule

// File: rtl/contador_cascata.sv
// Cascade of DIGITS loadable modulo-MOD digits with a same-edge carry chain.
// Optional CONTADOR_HOLD_AT_END_EN stops down-counting at all-zeros.
module contador_cascata
  import contador_cascata_pkg::*;
#(
  parameter int unsigned MOD    = DEF_MOD,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [DIGITS*WIDTH-1:0] data,
  input  logic                    loadn,
  input  logic                    en,
  input  logic                    up,
  output logic [DIGITS*WIDTH-1:0] count,
  output logic                    count_end,
  output logic                    tc
);

  // carry[i] is high when digit i is allowed to step this cycle.
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] at_term;
  logic              hold_end;

  assign carry[0] = en;

`ifdef CONTADOR_HOLD_AT_END_EN
  assign hold_end = ~up & (count == '0);
`else
  assign hold_end = 1'b0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign carry[i+1] = carry[i] & at_term[i];

    contador_digito #(
      .MOD   (MOD),
      .WIDTH (WIDTH)
    ) u_digito (
      .clk      (clk),
      .clear    (clear),
      .load     (~loadn),
      .load_val (data[i*WIDTH +: WIDTH]),
      .step     (carry[i] & ~hold_end),
      .up       (up),
      .value    (count[i*WIDTH +: WIDTH]),
      .at_term  (at_term[i])
    );
  end

  assign count_end = (count == '0);
  assign tc        = carry[DIGITS];

endmodule
